// File: rtl/ringosc_freq_counter_if.sv
// Measurement request / result interface for the ring oscillator frequency counter.
// master: controller side (drives start, win_len, result_ready).
// slave : counter side (drives busy, count, overflow, result_valid).
interface ringosc_freq_counter_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output start,
        output win_len,
        output result_ready,
        input  busy,
        input  count,
        input  overflow,
        input  result_valid
    );

    modport slave (
        input  start,
        input  win_len,
        input  result_ready,
        output busy,
        output count,
        output overflow,
        output result_valid
    );
endinterface

// File: rtl/ringosc_freq_counter.sv
// Counts rising edges of an asynchronous ring oscillator output over a
// programmable window of clk cycles and returns the count via valid/ready.
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   osc_in  ring oscillator output, asynchronous to clk
//   bus     slave side of ringosc_freq_counter_if
//           (start/win_len request, busy, count/overflow/result_valid/result_ready)
module ringosc_freq_counter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    osc_in,
    ringosc_freq_counter_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               hist_q;
    logic               rise_c;
    logic [WIN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.win_len != '0) begin
                        rem_d   = bus.win_len;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_COUNT;
                    end else begin
                        count_d    = '0;
                        overflow_d = 1'b0;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_COUNT: begin
                // Saturating accumulate; a rise at full scale flags overflow
                if (rise_c) begin
                    if (acc_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_q + CNT_W'(1);
                    end
                end
                rem_d = rem_q - WIN_W'(1);
                // Last window cycle: publish the value including this cycle's rise
                if (rem_q == WIN_W'(1)) begin
                    count_d    = acc_d;
                    overflow_d = ovf_d;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    assign bus.busy         = busy_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.result_valid = valid_q;

endmodule
